clock_time_setter: RTL

CLOCK_TIME_SETTER -- requirements
Module: clock_time_setter

---
 rtl/clock_time_setter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - 24h clock with RUN/SET_H/SET_M edit FSM, seconds prescaler and debounce tick divider
module clock_time_setter #(
    parameter int CLK_HZ  = 31500000,
    parameter int DEB_DIV = 39375
) (
    input  logic       regular_clk,
    input  logic       reset,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    output logic       deb_tick,
    output logic       sec_tick,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [4:0]         hours_q, hours_d;
    logic [5:0]         minutes_q, minutes_d;
    logic [5:0]         seconds_q, seconds_d;
    logic               sec_tick_q, sec_tick_d;

    logic               in_run;
    logic               in_set_h;
    logic               in_set_m;
    logic               sec_evt;
    logic               run_tick;
    logic               edit_inc;
    logic               edit_dec;

    // Mode state register
    always_ff @(posedge regular_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode advances only on mode_pulse, cycling RUN -> SET_H -> SET_M -> RUN
    always_comb begin
        state_d = state_q;
        if (mode_pulse) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Mode decode and blank-enable for the field being edited
    always_comb begin
        in_run   = (state_q == ST_RUN);
        in_set_h = (state_q == ST_SET_H);
        in_set_m = (state_q == ST_SET_M);
        blink    = !in_run && (pre_cnt_q < PRE_HALF);
    end

    // A mode press wins over any edit in the same cycle; inc+dec together cancel
    assign edit_inc = inc_pulse & ~dec_pulse & ~mode_pulse;
    assign edit_dec = dec_pulse & ~inc_pulse & ~mode_pulse;

    assign sec_evt  = (pre_cnt_q == PRE_MAX);
    // Leaving RUN freezes time immediately, so a tick coinciding with mode_pulse is dropped
    assign run_tick = in_run && !mode_pulse && sec_evt;
    assign deb_tick = (deb_cnt_q == DEB_MAX);

    // Free-running dividers; the prescaler restarts when returning to RUN
    always_comb begin
        deb_cnt_d = (deb_cnt_q == DEB_MAX) ? '0 : deb_cnt_q + 1'b1;
        if (sec_evt || (in_set_m && mode_pulse)) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // Timekeeping carry chain and field edits
    always_comb begin
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;
        if (in_run && mode_pulse) begin
            seconds_d = 6'd0;
        end else if (run_tick) begin
            sec_tick_d = 1'b1;
            if (seconds_q == 6'd59) begin
                seconds_d = 6'd0;
                if (minutes_q == 6'd59) begin
                    minutes_d = 6'd0;
                    hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end else if (in_set_h) begin
            if (edit_inc) begin
                hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else if (edit_dec) begin
                hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
            end
        end else if (in_set_m) begin
            if (edit_inc) begin
                minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
            end else if (edit_dec) begin
                minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge regular_clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_q  <= '0;
            deb_cnt_q  <= '0;
            hours_q    <= 5'd0;
            minutes_q  <= 6'd0;
            seconds_q  <= 6'd0;
            sec_tick_q <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign sec_tick = sec_tick_q;
    assign set_mode = state_q;

endmodule
